formula_1_pipe_top: RTL and testbench



---
 rtl/formula_1_pipe_top.sv | 91 +++++++++
 tb/tb_formula_1_pipe_top.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/formula_1_pipe_top.sv
// formula_1_pipe_top: fully pipelined res = isqrt(a) + isqrt(b) + isqrt(c), 16-cycle latency

// formula_1_isqrt_pipe: 16-stage floor square root, one root bit per stage, MSB first.
// Each stage carries x, the partial root and the partial root squared, so the
// trial square is built with adds and shifts instead of a multiplier:
// (root | 2^p)^2 = root^2 + (root << (p+1)) + 2^(2p), since root has no bits at or below p.
module formula_1_isqrt_pipe (
    input  logic        clk,
    input  logic [31:0] x_i,
    output logic [15:0] root_o
);
    logic [31:0] x_w  [16];
    logic [31:0] sq_w [16];
    logic [15:0] r_w  [17];

    assign x_w[0]  = x_i;
    assign sq_w[0] = '0;
    assign r_w[0]  = '0;

    for (genvar k = 0; k < 16; k++) begin : g_stage
        localparam int P = 15 - k;
        logic [15:0] trial;
        logic [15:0] root_d;
        logic [15:0] root_q;
        logic [31:0] trial_sq;
        logic        take;

        assign trial    = r_w[k] | (16'd1 << P);
        assign trial_sq = sq_w[k] + ({16'd0, r_w[k]} << (P + 1)) + (32'd1 << (2 * P));
        assign take     = trial_sq <= x_w[k];
        assign root_d   = take ? trial : r_w[k];

        // Register the partial root decided at this bit position
        always_ff @(posedge clk) begin
            root_q <= root_d;
        end

        assign r_w[k+1] = root_q;

        if (k < 15) begin : g_fwd
            logic [31:0] sq_d;
            logic [31:0] sq_q;
            logic [31:0] x_q;

            assign sq_d = take ? trial_sq : sq_w[k];

            // Carry the operand and the running root square to the next stage
            always_ff @(posedge clk) begin
                x_q  <= x_w[k];
                sq_q <= sq_d;
            end

            assign x_w[k+1]  = x_q;
            assign sq_w[k+1] = sq_q;
        end
    end

    assign root_o = r_w[16];
endmodule

module formula_1_pipe_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    output logic [31:0] res
);
    logic [15:0] vld_q;
    logic [15:0] vld_d;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rc;

    formula_1_isqrt_pipe u_sqrt_a (.clk(clk), .x_i(a), .root_o(ra));
    formula_1_isqrt_pipe u_sqrt_b (.clk(clk), .x_i(b), .root_o(rb));
    formula_1_isqrt_pipe u_sqrt_c (.clk(clk), .x_i(c), .root_o(rc));

    assign vld_d = {vld_q[14:0], arg_vld};

    // Valid bits walk alongside the data; reset flushes every in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    assign res_vld = vld_q[15];
    assign res     = {16'd0, ra} + {16'd0, rb} + {16'd0, rc};
endmodule

// File: tb/tb_formula_1_pipe_top.sv
// tb_formula_1_pipe_top: directed and random checks of the pipelined isqrt-sum datapath
module tb_formula_1_pipe_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arg_vld = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] c = '0;
    logic        res_vld;
    logic [31:0] res;

    typedef struct {
        logic [31:0] v;
        int          due;
    } exp_t;

    exp_t q[$];
    int   ncyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   armed = 1'b0;

    formula_1_pipe_top dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld),
        .a(a), .b(b), .c(c),
        .res_vld(res_vld), .res(res)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] isqrt_ref(input logic [31:0] x);
        longint unsigned lo = 0;
        longint unsigned hi = 65535;
        longint unsigned mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return 32'(lo);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return isqrt_ref(x) + isqrt_ref(y) + isqrt_ref(z);
    endfunction

    // Output monitor: every cycle res_vld must match the scoreboard, and res when valid
    always @(negedge clk) begin : mon
        logic exp_v;
        ncyc++;
        if (armed) begin
            exp_v = (q.size() > 0) && (q[0].due == ncyc);
            checks++;
            assert (res_vld === exp_v) else begin
                failures++;
                $error("FAIL res_vld cycle=%0d got=%b want=%b", ncyc, res_vld, exp_v);
            end
            if (exp_v) begin
                if (res_vld === 1'b1) begin
                    checks++;
                    assert (res === q[0].v) else begin
                        failures++;
                        $error("FAIL res cycle=%0d got=%0d want=%0d", ncyc, res, q[0].v);
                    end
                end
                void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic, input logic [31:0] ev);
        @(negedge clk);
        #1;
        a = ia;
        b = ib;
        c = ic;
        arg_vld = 1'b1;
        q.push_back('{v: ev, due: ncyc + 16});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            arg_vld = 1'b0;
            a = $urandom;
            b = $urandom;
            c = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int gi [7] = '{0, 1, 4, 13, 40, 121, 364};
        logic [31:0] gexp [7] = '{32'd1, 32'd3, 32'd6, 32'd11, 32'd20, 32'd37, 32'd64};
        logic [31:0] ra, rb, rc;

        @(negedge clk);
        #1 armed = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        checks++;
        assert (res_vld === 1'b0) else begin
            failures++;
            $error("FAIL reset_vld got=%b want=0", res_vld);
        end

        send(32'd1, 32'd4, 32'd9, 32'd6);
        idle(20);

        send(32'd0, 32'd0, 32'd0, 32'd0);
        send(32'd1, 32'd1, 32'd1, 32'd3);
        send(32'd4, 32'd4, 32'd4, 32'd6);
        send(32'd13, 32'd13, 32'd13, 32'd9);
        send(32'd40, 32'd40, 32'd40, 32'd18);
        idle(20);

        for (int i = 0; i < 7; i++) begin
            send(32'(gi[i]), 32'(gi[i] + 1), 32'(2 * gi[i]), gexp[i]);
            idle(gi[i] / 10);
        end
        idle(20);

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd196605);
        send(32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 32'd196605);
        send(32'hFFFE_0000, 32'hFFFE_0000, 32'hFFFE_0000, 32'd196602);
        idle(20);

        for (int i = 0; i < 8; i++) send($urandom, $urandom, $urandom, 32'd0);
        idle(5);
        @(negedge clk);
        #1;
        rst = 1'b1;
        arg_vld = 1'b0;
        q.delete();
        @(negedge clk);
        #1;
        arg_vld = 1'b1;
        a = 32'd100;
        b = 32'd100;
        c = 32'd100;
        @(negedge clk);
        #1 arg_vld = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        send(32'd2, 32'd3, 32'd1000, 32'd33);
        idle(20);

        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            rc = $urandom >> $urandom_range(0, 31);
            send(ra, rb, rc, model(ra, rb, rc));
            idle($urandom_range(0, 18));
        end

        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL drain pending=%0d want=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
